// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared buffer state encodings and width helper for the one-hot decoder
package decoder_pkg;

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  typedef enum logic [1:0] {
    ST_EMPTY = EMPTY,
    ST_ONE   = ONE,
    ST_FULL  = FULL
  } buf_state_e;

  function automatic int out_w(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/onehot_skid_buf.sv
// rtl/onehot_skid_buf.sv - 2-entry valid/ready buffer holding already-decoded words
module onehot_skid_buf
  import decoder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         accept;
  logic         deliver;

  // Ready looks only at registered state so out_ready never reaches in_ready.
  assign in_ready  = !rst && (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = out_valid ? main_q : '0;
  assign accept    = in_valid && in_ready;
  assign deliver   = out_valid && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_data;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && deliver) begin
          main_d = in_data;
        end else if (accept) begin
          skid_d  = in_data;
          state_d = ST_FULL;
        end else if (deliver) begin
          main_d  = '0;
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (deliver) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ST_ONE;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        main_d  = '0;
        skid_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

endmodule

// File: rtl/decoder_2to4_stream.sv
// rtl/decoder_2to4_stream.sv - streaming binary-to-one-hot decoder with skid-buffered output
module decoder_2to4_stream
  import decoder_pkg::*;
#(
  parameter int N     = 2,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_code,
  input  logic                  in_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [out_w(N)-1:0]   out_onehot,
  output logic [CNT_W-1:0]      acc_cnt
);

  localparam int OUT_W = out_w(N);

  logic [OUT_W-1:0] word;

  function automatic logic [OUT_W-1:0] decode(input logic en, input logic [N-1:0] code);
    logic [OUT_W-1:0] w;
    w = '0;
    if (en) w[code] = 1'b1;
    return w;
  endfunction

  // Decoding before the buffer means both entries already hold final words.
  assign word = decode(in_en, in_code);

  onehot_skid_buf #(
    .W(OUT_W)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_onehot)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt <= '0;
    end else if (in_valid && in_ready) begin
      acc_cnt <= acc_cnt + CNT_W'(1);
    end
  end

endmodule
